// File: rtl/perf_counter_bank.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : perf_counter_bank                                            |
// | Description : Performance-counter bank. It accumulates the cycle count,    |
// |               global events and per-warp stall pulses. The live counters   |
// |               are snapshotted into a shadow bank on a periodic timer and   |
// |               once when the kernel finishes. The shadow bank is streamed   |
// |               out over a valid/ready interface.                            |
// | Option      : PERF_COUNTER_SATURATE_EN makes the counters saturate and     |
// |               adds a sticky overflow bit per counter in the beat MSB.      |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module perf_counter_bank #(
   parameter int NUM_WARPS       = 8,
   parameter int NUM_EVENTS      = 5,
   parameter int NUM_STALL_KINDS = 2,
   parameter int COUNTER_WIDTH   = 64,
   parameter int PERIOD_WIDTH    = 32,
   localparam int N_CTR = 1 + NUM_EVENTS + NUM_WARPS * NUM_STALL_KINDS,
   localparam int IDX_W = ($clog2(N_CTR) > 1) ? $clog2(N_CTR) : 1
) (
   input  logic                                 clock,
   input  logic                                 reset,
   input  logic                                 enable,
   input  logic                                 clear,
   input  logic [NUM_EVENTS-1:0]                event_inc,
   input  logic [NUM_WARPS*NUM_STALL_KINDS-1:0] stall_inc,
   input  logic [PERIOD_WIDTH-1:0]              sample_period,
   input  logic                                 finished,
   output logic                                 out_valid,
   input  logic                                 out_ready,
   output logic [IDX_W-1:0]                     out_index,
   output logic [COUNTER_WIDTH-1:0]             out_data,
   output logic                                 out_last,
   output logic                                 out_final,
   output logic                                 busy,
   output logic [15:0]                          dropped_samples
);

   // Live counters keep one bit less when the top bit carries the overflow flag.
`ifdef PERF_COUNTER_SATURATE_EN
   localparam int VAL_W = COUNTER_WIDTH - 1;
`else
   localparam int VAL_W = COUNTER_WIDTH;
`endif

   localparam logic [IDX_W-1:0] c_LAST_IDX = IDX_W'(N_CTR - 1);
   localparam logic [VAL_W-1:0] c_VAL_MAX  = {VAL_W{1'b1}};

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_DUMP = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t                     state_q, state_d;
   logic [VAL_W-1:0]           ctr_q [N_CTR];
   logic [VAL_W-1:0]           ctr_d [N_CTR];
   logic [COUNTER_WIDTH-1:0]   shadow_q [N_CTR];
   logic [PERIOD_WIDTH-1:0]    timer_q, timer_d;
   logic [IDX_W-1:0]           index_q, index_d;
   logic                       final_q, final_d;
   logic                       pending_q, pending_d;
   logic                       fin_q;
   logic                       fin_seen_q;
   logic [15:0]                dropped_q, dropped_d;
`ifdef PERF_COUNTER_SATURATE_EN
   logic [N_CTR-1:0]           ovf_q, ovf_d;
`endif

   logic [N_CTR-1:0]           w_inc;
   logic                       w_count_en;
   logic                       w_timer_en;
   logic                       w_per_trig;
   logic                       w_fin_trig;
   logic                       w_snap;
   logic                       w_drop;

   // Index 0 is the cycle counter, then events, then warp-major stall counters.
   assign w_inc      = {stall_inc, event_inc, 1'b1};
   assign w_count_en = enable && (state_q != S_DONE);
   assign w_timer_en = w_count_en && (sample_period != '0);
   // Compare with >= so a period shortened on the fly still wraps promptly.
   assign w_per_trig = w_timer_en && (timer_q >= (sample_period - PERIOD_WIDTH'(1)));
   assign w_fin_trig = finished && !fin_q && !fin_seen_q && (state_q != S_DONE);

   assign out_index       = index_q;
   assign out_data        = shadow_q[index_q];
   assign dropped_samples = dropped_q;

   // Live-counter next state: clear wins over any increment in the same cycle.
   always_comb begin
`ifdef PERF_COUNTER_SATURATE_EN
      ovf_d = ovf_q;
`endif
      for (int i = 0; i < N_CTR; i++) begin
         ctr_d[i] = ctr_q[i];
         if (clear) begin
            ctr_d[i] = '0;
`ifdef PERF_COUNTER_SATURATE_EN
            ovf_d[i] = 1'b0;
`endif
         end else if (w_count_en && w_inc[i]) begin
`ifdef PERF_COUNTER_SATURATE_EN
            if (ctr_q[i] != c_VAL_MAX) begin
               ctr_d[i] = ctr_q[i] + VAL_W'(1);
               if (ctr_q[i] == (c_VAL_MAX - VAL_W'(1))) begin
                  ovf_d[i] = 1'b1;
               end
            end
`else
            ctr_d[i] = ctr_q[i] + VAL_W'(1);
`endif
         end
      end
   end

   // Sample timer: counts enabled cycles and wraps on each periodic trigger.
   always_comb begin
      timer_d = timer_q;
      if (clear) begin
         timer_d = '0;
      end else if (w_per_trig) begin
         timer_d = '0;
      end else if (w_timer_en) begin
         timer_d = timer_q + PERIOD_WIDTH'(1);
      end
   end

   // Dump FSM next state and stream outputs; finish outranks periodic.
   always_comb begin
      state_d   = state_q;
      index_d   = index_q;
      final_d   = final_q;
      pending_d = pending_q;
      w_snap    = 1'b0;
      w_drop    = 1'b0;
      out_valid = 1'b0;
      busy      = 1'b0;
      out_last  = 1'b0;
      out_final = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (w_fin_trig || pending_q) begin
               w_snap    = 1'b1;
               final_d   = 1'b1;
               pending_d = 1'b0;
               index_d   = '0;
               state_d   = S_DUMP;
               w_drop    = w_per_trig;
            end else if (w_per_trig) begin
               w_snap  = 1'b1;
               final_d = 1'b0;
               index_d = '0;
               state_d = S_DUMP;
            end
         end
         S_DUMP: begin
            out_valid = 1'b1;
            busy      = 1'b1;
            out_last  = (index_q == c_LAST_IDX);
            out_final = final_q;
            w_drop    = w_per_trig;
            if (w_fin_trig) begin
               pending_d = 1'b1;
            end
            if (out_ready) begin
               if (index_q == c_LAST_IDX) begin
                  index_d = '0;
                  if (final_q) begin
                     state_d = S_DONE;
                  end else if (pending_q || w_fin_trig) begin
                     w_snap    = 1'b1;
                     final_d   = 1'b1;
                     pending_d = 1'b0;
                  end else begin
                     state_d = S_IDLE;
                  end
               end else begin
                  index_d = index_q + IDX_W'(1);
               end
            end
         end
         S_DONE: begin
            state_d = S_DONE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // Lost periodic samples are counted and pinned at the top of the range.
   always_comb begin
      dropped_d = dropped_q;
      if (w_drop && (dropped_q != 16'hFFFF)) begin
         dropped_d = dropped_q + 16'd1;
      end
   end

   // Live counters and shadow bank; the shadow takes pre-increment values.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < N_CTR; i++) begin
            ctr_q[i]    <= '0;
            shadow_q[i] <= '0;
         end
      end else begin
         for (int i = 0; i < N_CTR; i++) begin
            ctr_q[i] <= ctr_d[i];
            if (w_snap) begin
`ifdef PERF_COUNTER_SATURATE_EN
               shadow_q[i] <= {ovf_q[i], ctr_q[i]};
`else
               shadow_q[i] <= ctr_q[i];
`endif
            end
         end
      end
   end

`ifdef PERF_COUNTER_SATURATE_EN
   // Sticky per-counter overflow flags.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         ovf_q <= '0;
      end else begin
         ovf_q <= ovf_d;
      end
   end
`endif

   // Control registers: FSM, timer, beat index, trigger bookkeeping.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q    <= S_IDLE;
         timer_q    <= '0;
         index_q    <= '0;
         final_q    <= 1'b0;
         pending_q  <= 1'b0;
         fin_q      <= 1'b0;
         fin_seen_q <= 1'b0;
         dropped_q  <= '0;
      end else begin
         state_q    <= state_d;
         timer_q    <= timer_d;
         index_q    <= index_d;
         final_q    <= final_d;
         pending_q  <= pending_d;
         fin_q      <= finished;
         fin_seen_q <= fin_seen_q || w_fin_trig;
         dropped_q  <= dropped_d;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_perf_counter_bank.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_perf_counter_bank                                         |
// | Description : Scoreboard bench for perf_counter_bank (8-bit counters).     |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module tb_perf_counter_bank;

   localparam int NW = 8;
   localparam int NE = 5;
   localparam int NK = 2;
   localparam int CW = 8;
   localparam int PW = 32;
   localparam int NC = 1 + NE + NW * NK;
   localparam int IW = 5;

   logic              clock = 1'b0;
   logic              reset = 1'b0;
   logic              enable = 1'b0;
   logic              clear = 1'b0;
   logic [NE-1:0]     event_inc = '0;
   logic [NW*NK-1:0]  stall_inc = '0;
   logic [PW-1:0]     sample_period = '0;
   logic              finished = 1'b0;
   logic              out_ready = 1'b0;
   logic              out_valid;
   logic [IW-1:0]     out_index;
   logic [CW-1:0]     out_data;
   logic              out_last;
   logic              out_final;
   logic              busy;
   logic [15:0]       dropped_samples;

   typedef struct {
      int          idx;
      logic [CW-1:0] data;
      logic        last;
      logic        fin;
   } beat_t;

   beat_t exp_q[$];
   int    checks = 0;
   int    errors = 0;

   perf_counter_bank #(
      .NUM_WARPS       (NW),
      .NUM_EVENTS      (NE),
      .NUM_STALL_KINDS (NK),
      .COUNTER_WIDTH   (CW),
      .PERIOD_WIDTH    (PW)
   ) dut (
      .clock           (clock),
      .reset           (reset),
      .enable          (enable),
      .clear           (clear),
      .event_inc       (event_inc),
      .stall_inc       (stall_inc),
      .sample_period   (sample_period),
      .finished        (finished),
      .out_valid       (out_valid),
      .out_ready       (out_ready),
      .out_index       (out_index),
      .out_data        (out_data),
      .out_last        (out_last),
      .out_final       (out_final),
      .busy            (busy),
      .dropped_samples (dropped_samples)
   );

   always #5 clock = ~clock;

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b0; enable = 1'b0; clear = 1'b0; event_inc = '0; stall_inc = '0;
      sample_period = '0; finished = 1'b0; out_ready = 1'b0;
      repeat (3) tick();
      reset = 1'b1;
   endtask

   // Queue one full expected dump: values per index, last on the final beat.
   task automatic push_dump(input logic [CW-1:0] v [NC], input logic fin);
      beat_t b;
      for (int i = 0; i < NC; i++) begin
         b.idx = i; b.data = v[i]; b.last = (i == NC - 1); b.fin = fin;
         exp_q.push_back(b);
      end
   endtask

   task automatic test_reset();
      reset = 1'b0;
      repeat (2) tick();
      checks++;
      if ({out_valid, busy, out_index, out_data, out_last, out_final, dropped_samples} !== '0) begin
         errors++;
         $display("FAIL reset_outputs: got valid=%b busy=%b idx=%0d data=%0d last=%b final=%b dropped=%0d, expected all 0",
                  out_valid, busy, out_index, out_data, out_last, out_final, dropped_samples);
      end
      do_reset();
      tick();
      checks++;
      if ({out_valid, busy, dropped_samples} !== '0) begin
         errors++;
         $display("FAIL reset_idle: got valid=%b busy=%b dropped=%0d, expected 0 0 0", out_valid, busy, dropped_samples);
      end
   endtask

   task automatic test_final_dump();
      logic [CW-1:0] v [NC];
      beat_t e;
      int first_t = -1;
      int seen = 0;
      do_reset();
      enable = 1'b1; out_ready = 1'b1;
      event_inc = 5'b00001;
      repeat (10) tick();
      event_inc = '0;
      repeat (10) tick();
      foreach (v[i]) v[i] = '0;
      v[0] = 8'd20; v[1] = 8'd10;
      push_dump(v, 1'b1);
      finished = 1'b1;
      for (int t = 0; t <= 40; t++) begin
         if (out_valid && out_ready) begin
            if (first_t < 0) first_t = t;
            checks++;
            if (exp_q.size() == 0) begin
               errors++; $display("FAIL final_beat: got beat idx=%0d, expected none", out_index);
            end else begin
               e = exp_q.pop_front();
               if ({out_index, out_data, out_last, out_final} !== {IW'(e.idx), e.data, e.last, e.fin}) begin
                  errors++;
                  $display("FAIL final_beat: got idx=%0d data=%0d last=%b final=%b, expected idx=%0d data=%0d last=%b final=%b",
                           out_index, out_data, out_last, out_final, e.idx, e.data, e.last, e.fin);
               end
            end
         end
         tick();
      end
      checks++;
      if (first_t != 1) begin
         errors++; $display("FAIL final_latency: got first beat at cycle %0d, expected 1", first_t);
      end
      checks++;
      if (exp_q.size() != 0) begin
         errors++; $display("FAIL final_count: got %0d beats missing, expected 0", exp_q.size());
         exp_q.delete();
      end
      checks++;
      if ({out_valid, busy} !== 2'b00) begin
         errors++; $display("FAIL final_done: got valid=%b busy=%b, expected 0 0", out_valid, busy);
      end
      finished = 1'b0;
      tick();
      finished = 1'b1;
      for (int t = 0; t < 6; t++) begin
         tick();
         if (out_valid) seen++;
      end
      checks++;
      if (seen != 0) begin
         errors++; $display("FAIL done_sticky: got %0d valid cycles after second finish, expected 0", seen);
      end
   endtask

   task automatic test_periodic();
      logic [CW-1:0] v [NC];
      beat_t e;
      int starts = 0;
      do_reset();
      enable = 1'b1; out_ready = 1'b1; sample_period = 32'd50;
      foreach (v[i]) v[i] = '0;
      for (int d = 1; d <= 3; d++) begin
         v[0] = CW'(50 * d - 1);
         push_dump(v, 1'b0);
      end
      for (int t = 0; t <= 175; t++) begin
         if (out_valid && out_index == '0) begin
            starts++;
            checks++;
            if (t != 50 * starts) begin
               errors++; $display("FAIL periodic_start: got dump %0d at cycle %0d, expected %0d", starts, t, 50 * starts);
            end
         end
         if (out_valid && out_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
               errors++; $display("FAIL periodic_beat: got beat idx=%0d, expected none", out_index);
            end else begin
               e = exp_q.pop_front();
               if ({out_index, out_data, out_last, out_final} !== {IW'(e.idx), e.data, e.last, e.fin}) begin
                  errors++;
                  $display("FAIL periodic_beat: got idx=%0d data=%0d last=%b final=%b, expected idx=%0d data=%0d last=%b final=%b",
                           out_index, out_data, out_last, out_final, e.idx, e.data, e.last, e.fin);
               end
            end
         end
         tick();
      end
      checks++;
      if (exp_q.size() != 0 || starts != 3) begin
         errors++; $display("FAIL periodic_count: got %0d dumps, %0d beats missing, expected 3 and 0", starts, exp_q.size());
         exp_q.delete();
      end
      checks++;
      if (dropped_samples !== 16'd0) begin
         errors++; $display("FAIL periodic_dropped: got %0d, expected 0", dropped_samples);
      end
   endtask

   task automatic test_backpressure();
      logic [CW-1:0] v [NC];
      beat_t e;
      do_reset();
      enable = 1'b1; out_ready = 1'b0; sample_period = 32'd4;
      for (int t = 0; t <= 24; t++) begin
         if (t >= 4) begin
            checks++;
            if ({out_valid, out_index, out_data, out_last, out_final} !== {1'b1, IW'(0), CW'(3), 1'b0, 1'b0}) begin
               errors++;
               $display("FAIL stall_stable: cycle %0d got valid=%b idx=%0d data=%0d last=%b final=%b, expected 1 0 3 0 0",
                        t, out_valid, out_index, out_data, out_last, out_final);
            end
         end
         if (t == 7 || t == 24) begin
            checks++;
            if (dropped_samples !== ((t == 7) ? 16'd0 : 16'd5)) begin
               errors++; $display("FAIL stall_dropped: cycle %0d got %0d, expected %0d", t, dropped_samples, (t == 7) ? 0 : 5);
            end
         end
         if (t < 24) tick();
      end
      sample_period = 32'd1;
      repeat (65540) tick();
      checks++;
      if (dropped_samples !== 16'hFFFF || out_index !== '0) begin
         errors++; $display("FAIL dropped_saturate: got dropped=%0h idx=%0d, expected ffff and 0", dropped_samples, out_index);
      end
      sample_period = '0;
      out_ready = 1'b1;
      foreach (v[i]) v[i] = '0;
      v[0] = 8'd3;
      push_dump(v, 1'b0);
      for (int t = 0; t <= 30; t++) begin
         if (out_valid && out_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
               errors++; $display("FAIL drain_beat: got beat idx=%0d, expected none", out_index);
            end else begin
               e = exp_q.pop_front();
               if ({out_index, out_data, out_last, out_final} !== {IW'(e.idx), e.data, e.last, e.fin}) begin
                  errors++;
                  $display("FAIL drain_beat: got idx=%0d data=%0d last=%b final=%b, expected idx=%0d data=%0d last=%b final=%b",
                           out_index, out_data, out_last, out_final, e.idx, e.data, e.last, e.fin);
               end
            end
         end
         tick();
      end
      checks++;
      if (exp_q.size() != 0 || out_valid !== 1'b0) begin
         errors++; $display("FAIL drain_end: got %0d beats missing valid=%b, expected 0 and 0", exp_q.size(), out_valid);
         exp_q.delete();
      end
   endtask

   task automatic test_finish_mid_dump();
      logic [CW-1:0] v [NC];
      beat_t e;
      int exp_start [2] = '{10, 32};
      int starts = 0;
      do_reset();
      enable = 1'b1; out_ready = 1'b1; sample_period = 32'd10;
      foreach (v[i]) v[i] = '0;
      v[0] = 8'd9;
      push_dump(v, 1'b0);
      v[0] = 8'd31;
      push_dump(v, 1'b1);
      for (int t = 0; t <= 70; t++) begin
         if (out_valid && out_index == '0) begin
            checks++;
            if (starts >= 2 || t != exp_start[starts]) begin
               errors++; $display("FAIL mid_start: got dump start at cycle %0d, expected %0d", t, (starts < 2) ? exp_start[starts] : -1);
            end
            starts++;
         end
         if (out_valid && out_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
               errors++; $display("FAIL mid_beat: got beat idx=%0d, expected none", out_index);
            end else begin
               e = exp_q.pop_front();
               if ({out_index, out_data, out_last, out_final} !== {IW'(e.idx), e.data, e.last, e.fin}) begin
                  errors++;
                  $display("FAIL mid_beat: got idx=%0d data=%0d last=%b final=%b, expected idx=%0d data=%0d last=%b final=%b",
                           out_index, out_data, out_last, out_final, e.idx, e.data, e.last, e.fin);
               end
            end
         end
         if (t == 15) finished = 1'b1;
         tick();
      end
      checks++;
      if (exp_q.size() != 0 || dropped_samples !== 16'd4 || busy !== 1'b0) begin
         errors++; $display("FAIL mid_end: got missing=%0d dropped=%0d busy=%b, expected 0 4 0", exp_q.size(), dropped_samples, busy);
         exp_q.delete();
      end
   endtask

   task automatic test_clear_enable();
      logic [CW-1:0] v [NC];
      beat_t e;
      do_reset();
      enable = 1'b1; out_ready = 1'b1;
      event_inc = 5'b00010;
      repeat (7) tick();
      clear = 1'b1;
      tick();
      clear = 1'b0; event_inc = '0;
      repeat (2) tick();
      enable = 1'b0; event_inc = 5'b00010;
      repeat (3) tick();
      foreach (v[i]) v[i] = '0;
      v[0] = 8'd2;
      push_dump(v, 1'b1);
      finished = 1'b1;
      for (int t = 0; t <= 30; t++) begin
         if (out_valid && out_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
               errors++; $display("FAIL clear_beat: got beat idx=%0d, expected none", out_index);
            end else begin
               e = exp_q.pop_front();
               if ({out_index, out_data, out_last, out_final} !== {IW'(e.idx), e.data, e.last, e.fin}) begin
                  errors++;
                  $display("FAIL clear_beat: got idx=%0d data=%0d last=%b final=%b, expected idx=%0d data=%0d last=%b final=%b",
                           out_index, out_data, out_last, out_final, e.idx, e.data, e.last, e.fin);
               end
            end
         end
         tick();
      end
      checks++;
      if (exp_q.size() != 0) begin
         errors++; $display("FAIL clear_count: got %0d beats missing, expected 0", exp_q.size());
         exp_q.delete();
      end
   endtask

   task automatic test_wrap();
      logic [CW-1:0] v [NC];
      beat_t e;
      do_reset();
      enable = 1'b1; out_ready = 1'b1;
      stall_inc = 16'h8001; event_inc = 5'b10000;
      repeat (3) tick();
      stall_inc = 16'h0001;
      repeat (2) tick();
      event_inc = '0;
      repeat (295) tick();
      stall_inc = '0;
      foreach (v[i]) v[i] = '0;
`ifdef PERF_COUNTER_SATURATE_EN
      v[0] = 8'hFF; v[6] = 8'hFF;
`else
      v[0] = 8'd44; v[6] = 8'd44;
`endif
      v[5] = 8'd5; v[21] = 8'd3;
      push_dump(v, 1'b1);
      finished = 1'b1;
      for (int t = 0; t <= 30; t++) begin
         if (out_valid && out_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
               errors++; $display("FAIL wrap_beat: got beat idx=%0d, expected none", out_index);
            end else begin
               e = exp_q.pop_front();
               if ({out_index, out_data, out_last, out_final} !== {IW'(e.idx), e.data, e.last, e.fin}) begin
                  errors++;
                  $display("FAIL wrap_beat: got idx=%0d data=%0d last=%b final=%b, expected idx=%0d data=%0d last=%b final=%b",
                           out_index, out_data, out_last, out_final, e.idx, e.data, e.last, e.fin);
               end
            end
         end
         tick();
      end
      checks++;
      if (exp_q.size() != 0) begin
         errors++; $display("FAIL wrap_count: got %0d beats missing, expected 0", exp_q.size());
         exp_q.delete();
      end
   endtask

   task automatic test_reset_abort();
      do_reset();
      enable = 1'b1; out_ready = 1'b0; sample_period = 32'd4;
      repeat (4) tick();
      checks++;
      if (out_valid !== 1'b1) begin
         errors++; $display("FAIL abort_pre: got valid=%b, expected 1", out_valid);
      end
      #2;
      reset = 1'b0;
      #1;
      checks++;
      if ({out_valid, busy, out_index, out_data, dropped_samples} !== '0) begin
         errors++;
         $display("FAIL abort_async: got valid=%b busy=%b idx=%0d data=%0d dropped=%0d, expected all 0",
                  out_valid, busy, out_index, out_data, dropped_samples);
      end
      tick();
      reset = 1'b1;
   endtask

   initial begin
      test_reset();
      test_final_dump();
      test_periodic();
      test_backpressure();
      test_finish_mid_dump();
      test_clear_enable();
      test_wrap();
      test_reset_abort();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/perf_counter_bank.md
Name: perf_counter_bank

Overview:
- Parametrised hardware performance-counter bank. It accumulates core event and per-warp stall pulses into counters held in RTL.
- It snapshots all counters periodically, and once at kernel finish, into a shadow bank.
- The shadow bank is streamed over a valid/ready interface to a trace sink, so no per-cycle DPI call is needed.
- Sits beside the core's issue/retire logic; event and stall counts are generalised by parameter.

Parameters:
- NUM_WARPS, 8, warps tracked for per-warp stall counters.
- NUM_EVENTS, 5, global event inputs (e.g. retired, decoded, eligible, issued, ...).
- NUM_STALL_KINDS, 2, stall categories per warp (e.g. WAW, WAR).
- COUNTER_WIDTH, 64, width of every counter and of out_data.
- PERIOD_WIDTH, 32, width of sample_period and the internal sample timer.
- Derived: N_CTR = 1 + NUM_EVENTS + NUM_WARPS*NUM_STALL_KINDS; IDX_W = max(1, clog2(N_CTR)).

Ports:
- clock  in  1  sole clock.
- reset  in  1  asynchronous, active-low reset (asserted when 0).
- enable  in  1  counters and sample timer advance only when 1.
- clear  in  1  synchronous zero of live counters and sample timer.
- event_inc  in  NUM_EVENTS  bit e: increment event counter e this cycle.
- stall_inc  in  NUM_WARPS*NUM_STALL_KINDS  bit w*NUM_STALL_KINDS+k: increment stall counter for warp w, kind k.
- sample_period  in  PERIOD_WIDTH  cycles between periodic snapshots; 0 disables periodic sampling.
- finished  in  1  kernel done; a rising edge triggers the final snapshot.
- out_valid  out  1  stream beat valid.
- out_ready  in  1  sink accepts the beat.
- out_index  out  IDX_W  counter index of the current beat.
- out_data  out  COUNTER_WIDTH  shadow counter value.
- out_last  out  1  beat is index N_CTR-1.
- out_final  out  1  beat belongs to the finish-triggered dump.
- busy  out  1  dump in progress (state DUMP).
- dropped_samples  out  16  count of periodic triggers lost while busy; saturates at 0xFFFF.

Behaviour:
- Reset: all counters, shadow bank, timer, index, pending flag and dropped_samples go to 0. State goes to IDLE. All outputs read 0.
- Counter index map:
  - 0 = cycle counter (+1 every enabled cycle).
  - 1..NUM_EVENTS = event_inc[e] mapped to index 1+e.
  - Stall counters at 1+NUM_EVENTS+w*NUM_STALL_KINDS+k.
- Increments are 1 per cycle per counter.
- enable=0: counters and timer hold. The finished edge is still detected.
- clear: all live counters and the timer become 0 next cycle. Clear beats any same-cycle increment. Shadow bank and any dump in progress are unaffected.
- Timer: with enable=1 and sample_period!=0, the timer counts up. When it reaches sample_period-1 it wraps to 0 and raises a periodic trigger.
- Finish trigger: rising edge of finished, registered; at most one per reset.
- FSM states IDLE, DUMP, DONE:
  - IDLE, trigger present: on that edge, copy all live counters into the shadow bank, set index=0, latch out_final (1 if finish trigger), go to DUMP.
  - If both triggers arrive together, the finish trigger wins; the periodic trigger is dropped and counted.
  - The shadow bank takes the pre-increment register values of that cycle.
- DUMP:
  - out_valid=1; out_data=shadow[index].
  - out_index, out_data, out_last and out_final stay stable until out_valid & out_ready.
  - On accept: index+1. After accepting index N_CTR-1, go to DONE if out_final=1. Otherwise go to IDLE, or straight to a new snapshot if a finish is pending.
- Triggers during DUMP:
  - Periodic: dropped, dropped_samples+1 (saturating).
  - Finish: sets the pending flag, which is serviced on the first cycle after the current dump ends.
- DONE: out_valid=0, busy=0; counters freeze; no further triggers. Exit only via reset.
- Latency: trigger at edge t gives out_valid=1 in cycle t+1. A full dump takes at least N_CTR cycles.
- Counters wrap modulo 2^COUNTER_WIDTH unless the optional feature below is compiled in.
- Reset asserted mid-dump aborts the dump immediately; out_valid drops asynchronously.

Optional Feature:
- Macro: PERF_COUNTER_SATURATE_EN.
- Defined: every live counter saturates at all-ones instead of wrapping, and a sticky overflow bit per counter is set on the saturation cycle. Each beat carries the counter's bit in out_data MSB. The value field shrinks to COUNTER_WIDTH-1 bits and saturates at 2^(COUNTER_WIDTH-1)-1.
- Absent: plain modulo wrap; full COUNTER_WIDTH value; no overflow bits.

Test Plan:
- Reset, enable=1, pulse event_inc[0] 10 cycles, finished rises at cycle 20, out_ready=1 -> N_CTR beats: index0 = 20, index1 = 10, others 0, out_final=1 on all, out_last only on the final beat, then DONE.
- sample_period=50, no events, out_ready=1 -> dumps begin at cycles 50, 100, 150. Index-0 values 49, 99, 149 (pre-increment). dropped_samples=0.
- sample_period=4 with out_ready=0 -> the first dump stalls with out_valid/out_data stable. dropped_samples increments every 4 cycles; no second dump starts.
- finished rises mid-periodic dump -> the periodic dump completes with out_final=0, then a final dump starts the next cycle with out_final=1.
- clear and event_inc[1] asserted in the same cycle with count 7 -> counter 1 reads 0 at the next snapshot.
- COUNTER_WIDTH=8, 300 stall_inc pulses on warp 0, kind 0 -> reads 44 (300 mod 256). With PERF_COUNTER_SATURATE_EN: value field 127 with out_data MSB set.
